// File: rtl/countdown_controller_if.sv
// rtl/countdown_controller_if.sv - command/status bundle between front panel and countdown controller
interface countdown_controller_if #(
    parameter int TIME_W = 12,
    parameter int MODE_W = 4,
    parameter int STEP_W = 4
);
    logic [MODE_W-1:0] mode;
    logic              load;
    logic [TIME_W-1:0] load_time;
    logic              start;
    logic              pause;
    logic              cancel;
    logic [TIME_W-1:0] present_time;
    logic [STEP_W-1:0] counter_input;
    logic              counter_enable;
    logic              is_running;
    logic              done;
    logic              mode_err;

    modport master (
        output mode, load, load_time, start, pause, cancel,
        input  present_time, counter_input, counter_enable, is_running, done, mode_err
    );

    modport slave (
        input  mode, load, load_time, start, pause, cancel,
        output present_time, counter_input, counter_enable, is_running, done, mode_err
    );
endinterface

// File: rtl/countdown_controller.sv
// rtl/countdown_controller.sv - prescaled countdown with start/pause/cancel/reload and done pulse
module countdown_controller #(
    parameter int                 TIME_W   = 12,
    parameter int                 MODE_W   = 4,
    parameter int                 STEP_W   = 4,
    parameter int                 TICK_DIV = 1000,
    parameter logic [MODE_W-1:0]  MODE_A   = 4'b0010,
    parameter int                 STEP_A   = 1,
    parameter logic [MODE_W-1:0]  MODE_B   = 4'b1010,
    parameter int                 STEP_B   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    countdown_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_DONE} state_t;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_A_V = STEP_W'(STEP_A);
    localparam logic [STEP_W-1:0] STEP_B_V = STEP_W'(STEP_B);

    state_t            r_state;
    logic [TIME_W-1:0] r_time;
    logic [PW-1:0]     r_presc;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_cnt_in;
    logic              r_cnt_en;
    logic              r_is_run;
    logic              r_done;
    logic              r_mode_err;

    logic [TIME_W:0]   w_diff;
    logic              w_sat;
    logic              w_tick;

    // One extra bit catches underflow; time <= step means the next tick lands on zero.
    assign w_diff = {1'b0, r_time} - {{(TIME_W + 1 - STEP_W){1'b0}}, r_step};
    assign w_sat  = w_diff[TIME_W] || (w_diff == '0);
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_time     <= '0;
            r_presc    <= '0;
            r_step     <= '0;
            r_cnt_in   <= '0;
            r_cnt_en   <= 1'b0;
            r_is_run   <= 1'b0;
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
            if (bus.cancel) begin
                r_state  <= S_IDLE;
                r_time   <= '0;
                r_presc  <= '0;
                r_step   <= '0;
                r_cnt_in <= '0;
                r_cnt_en <= 1'b0;
                r_is_run <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.load) begin
                            r_time <= bus.load_time;
                        end else if (bus.start && (r_time != '0)) begin
                            if (bus.mode == MODE_A || bus.mode == MODE_B) begin
                                r_step   <= (bus.mode == MODE_A) ? STEP_A_V : STEP_B_V;
                                r_cnt_in <= (bus.mode == MODE_A) ? STEP_A_V : STEP_B_V;
                                r_presc  <= '0;
                                r_state  <= S_RUNNING;
                                r_cnt_en <= 1'b1;
                                r_is_run <= 1'b1;
                            end else begin
                                r_mode_err <= 1'b1;
                            end
                        end
                    end
                    S_RUNNING: begin
                        if (bus.pause) begin
                            r_state  <= S_PAUSED;
                            r_cnt_en <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_sat) begin
                                r_time   <= '0;
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_cnt_in <= '0;
                                r_cnt_en <= 1'b0;
                                r_is_run <= 1'b0;
                            end else begin
                                r_time <= w_diff[TIME_W-1:0];
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (bus.start) begin
                            r_state  <= S_RUNNING;
                            r_cnt_en <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_step  <= '0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.present_time   = r_time;
    assign bus.counter_input  = r_cnt_in;
    assign bus.counter_enable = r_cnt_en;
    assign bus.is_running     = r_is_run;
    assign bus.done           = r_done;
    assign bus.mode_err       = r_mode_err;
endmodule
